acc_ctrl_unit: RTL and testbench
================================

# acc_ctrl_unit

Fetch/decode/execute sequencer for the tiny accumulator processor. It fetches 8-bit instructions over a request/acknowledge port and owns the PC, accumulator (ACC), instruction register (IR) and an 8×8 register file. It drives the ALU select, operand and accumulator inputs, and retires each instruction by writing the ALU result back. It is the controlling side of the ALU interface: it issues the unit/op selects that the ALU consumes.

## Interface
- PC_W, 8, program counter and instruction-address width; PC wraps modulo 2^PC_W
- clk_in  input  1  clock; all state updates on rising edge
- rst_in  input  1  reset; one clock, reset is asynchronous and active-high
- imem_req_out  output  1  fetch request
- imem_addr_out  output  PC_W  fetch address, equals PC
- imem_ack_in  input  1  fetch acknowledge; data valid in the same cycle
- imem_data_in  input  8  instruction word
- alu_unit_sel_out  output  3  ALU unit select
- alu_op_sel_out  output  1  ALU op select
- alu_acc_out  output  8  ACC value to ALU
- alu_src_out  output  8  source operand to ALU
- alu_res_in  input  8  ALU result
- acc_out  output  8  ACC, for debug and pins
- pc_out  output  PC_W  PC
- halted_out  output  1  high in HALT

## Operation
- Instruction format: [7:4] opcode; [3] imm flag; [2:0] register index or immediate 0..7, zero-extended.
- Branch and jump use [3:0] as a signed offset (−8..+7) relative to the branch's own address.
- src = imm ? {5'b0,[2:0]} : reg[[2:0]].
- Opcodes, with unit/op driven:
  - 0 ADD 000/0; 1 SUB 000/1; 2 AND 001/0; 3 NAND 001/1
  - 4 SLL 010/0; 5 SRL 010/1; 6 MOV 011/0; 7 OR 100/0
  - 8 XOR 101/0; 9 MUL 110/0 (low 8 bits kept)
- Opcodes 0–9 write ACC <= alu_res_in.
- A ST: reg[[2:0]] <= ACC; with imm=1 it is a NOP. Drives 111/0.
- B BNEZ: drives 111/0. If alu_res_in != 0, PC <= PC + sext([3:0]); otherwise PC <= PC + 1.
- C JMP: PC <= PC + sext([3:0]) unconditionally. Drives 111/0.
- D NOP and F (reserved): no state change except PC+1.
- E HALT: enter HALT. PC is not incremented.
- All non-branch instructions: PC <= PC + 1, wrapping modulo 2^PC_W.
- State machine:
  - IDLE (reset state) → FETCH on the next edge.
  - FETCH: imem_req_out=1. On imem_ack_in=1, IR <= imem_data_in, go to EXEC. Otherwise stay; address is held stable.
  - EXEC: ALU outputs are decoded from IR. Writeback and PC update happen on the edge. Go to FETCH, or to HALT on opcode E.
  - HALT: terminal until reset. imem_req_out=0.
- In IDLE, FETCH and HALT, drive alu_unit_sel_out=111, alu_op_sel_out=0, alu_src_out=0.
- alu_acc_out = ACC at all times.
- imem_ack_in is ignored outside FETCH.

## Timing
- Reset values: state IDLE, PC=0, ACC=0, IR=0, all registers 0, imem_req_out=0, halted_out=0, ALU outputs 111/0/0.
- Reset asserted mid-fetch or mid-exec: all outputs reach reset values immediately. No writeback occurs. A pending request is abandoned and a late ack is ignored.
- Minimum 2 cycles per instruction: FETCH with same-cycle ack, then EXEC. Each ack wait cycle adds one.
- First request is asserted in the 2nd cycle after reset release.
- EXEC: ALU control outputs are combinational from IR and registers. alu_res_in is sampled at the end of the EXEC cycle.
- ST then an instruction reading the same register: the new value is visible, since the write completes before the next EXEC.
- halted_out rises on the edge that leaves EXEC for HALT.

## Test plan
- Reset then program {0x6D MOV #5, 0x0B ADD #3, 0xE0 HALT}, zero-wait ack → ACC=0x08, halted_out=1, PC=2, 6 cycles from first request to halt.
- Ack delayed 3 cycles on every fetch → imem_addr_out held stable while waiting; same final ACC; each instruction takes 5 cycles.
- {MOV #3, ST r2, MOV #0, SUB r2} → reg2=3, ACC=0xFD. Check the unit/op sequence 011/0, 111/0, 011/0, 000/1.
- Loop {MOV #3, SUB #1 at addr1, BNEZ −1 at addr2, HALT} → BNEZ taken twice then not taken, ACC=0, PC=3.
- PC_W=8: JMP −1 at address 0 → PC=0xFF. NOP at 0xFF → PC wraps to 0x00.
- rst_in pulsed while imem_req_out=1 and ACC=0x2A → req drops the same cycle, ACC=0. An ack arriving after reset does not load IR.

Source files
------------

// File: rtl/acc_ctrl_unit.sv
// acc_ctrl_unit: fetch/decode/execute sequencer for the tiny accumulator processor.
module acc_ctrl_unit #(
  parameter int PC_W = 8
) (
  input  logic            clk_in,
  input  logic            rst_in,
  output logic            imem_req_out,
  output logic [PC_W-1:0] imem_addr_out,
  input  logic            imem_ack_in,
  input  logic [7:0]      imem_data_in,
  output logic [2:0]      alu_unit_sel_out,
  output logic            alu_op_sel_out,
  output logic [7:0]      alu_acc_out,
  output logic [7:0]      alu_src_out,
  input  logic [7:0]      alu_res_in,
  output logic [7:0]      acc_out,
  output logic [PC_W-1:0] pc_out,
  output logic            halted_out
);
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;
  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, off;
  logic [7:0]      acc_q, acc_d, ir_q, ir_d, src;
  logic [7:0]      rf_q [8];
  logic            rf_we;
  logic [3:0]      opc, opc_m3;
  logic            imm;
  logic [2:0]      idx;
  assign opc    = ir_q[7:4];
  assign imm    = ir_q[3];
  assign idx    = ir_q[2:0];
  assign opc_m3 = opc - 4'd3;
  assign src    = imm ? {5'b0, idx} : rf_q[idx];
  assign off    = {{(PC_W-4){ir_q[3]}}, ir_q[3:0]};
  assign imem_addr_out = pc_q;
  assign alu_acc_out   = acc_q;
  assign acc_out       = acc_q;
  assign pc_out        = pc_q;
  assign halted_out    = state_q == HALT;
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    acc_d            = acc_q;
    ir_d             = ir_q;
    rf_we            = 1'b0;
    imem_req_out     = 1'b0;
    alu_unit_sel_out = 3'b111;
    alu_op_sel_out   = 1'b0;
    alu_src_out      = 8'h00;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        imem_req_out = 1'b1;
        if (imem_ack_in) begin
          ir_d    = imem_data_in;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // opcodes 0-5 pair up per unit; 6-9 each get their own unit
        alu_unit_sel_out = opc <= 4'd5 ? opc[3:1] : opc <= 4'd9 ? opc_m3[2:0] : 3'b111;
        alu_op_sel_out   = opc <= 4'd5 && opc[0];
        alu_src_out      = src;
        acc_d            = opc <= 4'd9 ? alu_res_in : acc_q;
        rf_we            = opc == 4'hA && !imm;
        pc_d             = opc == 4'hE ? pc_q :
                           opc == 4'hC || (opc == 4'hB && alu_res_in != 8'h00) ? pc_q + off :
                           pc_q + 1'b1;
        state_d          = opc == 4'hE ? HALT : FETCH;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      pc_q    <= '0;
      acc_q   <= 8'h00;
      ir_q    <= 8'h00;
      for (int i = 0; i < 8; i++) rf_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      ir_q    <= ir_d;
      if (rf_we) rf_q[idx] <= acc_q;
    end
  end
endmodule

// File: tb/tb_acc_ctrl_unit.sv
// tb_acc_ctrl_unit: directed programs against acc_ctrl_unit with a behavioural ALU and instruction memory.
module tb_acc_ctrl_unit;
  logic       clk = 0, rst = 1;
  logic       req, ack, halted, op;
  logic [7:0] addr, data, acc, alu_acc, src, res, pc;
  logic [2:0] unit;
  logic [7:0] mem [256];
  int         delay = 0, wcnt = 0;
  logic       ack_force = 0;
  int         tests = 0, fails = 0;
  int         cycles, ex_n;
  logic       addr_moved;
  logic [3:0] ex_uo [64];
  logic [7:0] ex_pc [64];

  always #5 clk = ~clk;

  acc_ctrl_unit #(.PC_W(8)) dut (
    .clk_in(clk), .rst_in(rst), .imem_req_out(req), .imem_addr_out(addr),
    .imem_ack_in(ack), .imem_data_in(data), .alu_unit_sel_out(unit),
    .alu_op_sel_out(op), .alu_acc_out(alu_acc), .alu_src_out(src),
    .alu_res_in(res), .acc_out(acc), .pc_out(pc), .halted_out(halted)
  );

  assign data = mem[addr];
  assign ack  = ack_force || (req && wcnt == delay);
  always @(posedge clk or posedge rst)
    if (rst) wcnt <= 0;
    else if (ack) wcnt <= 0;
    else if (req) wcnt <= wcnt + 1;

  always_comb begin
    res = alu_acc;
    case (unit)
      3'd0: res = op ? alu_acc - src : alu_acc + src;
      3'd1: res = op ? ~(alu_acc & src) : alu_acc & src;
      3'd2: res = op ? alu_acc >> src : alu_acc << src;
      3'd3: res = src;
      3'd4: res = alu_acc | src;
      3'd5: res = alu_acc ^ src;
      3'd6: res = 8'(alu_acc * src);
      default: res = alu_acc;
    endcase
  end

  task automatic load(input logic [7:0] p [$]);
    for (int i = 0; i < 256; i++) mem[i] = 8'hD0;
    foreach (p[i]) mem[i] = p[i];
  endtask

  task automatic do_reset();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic run_prog(input int dly);
    logic prev_ack, prev_wait, saw_req;
    logic [7:0] prev_addr;
    delay = dly;
    do_reset();
    ex_n = 0; cycles = 0; addr_moved = 0;
    prev_ack = 0; prev_wait = 0; saw_req = 0; prev_addr = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (halted) break;
      if (prev_ack && ex_n < 64) begin
        ex_uo[ex_n] = {unit, op};
        ex_pc[ex_n] = pc;
        ex_n++;
      end
      if (req) saw_req = 1;
      if (saw_req) cycles++;
      if (prev_wait && addr != prev_addr) addr_moved = 1;
      prev_ack  = req && ack;
      prev_wait = req && !ack;
      prev_addr = addr;
    end
  endtask

  task automatic test_reset();
    rst = 1;
    @(negedge clk);
    tests++; if (req !== 1'b0) begin fails++; $display("FAIL rst_req got %b want 0", req); end
    tests++; if (halted !== 1'b0) begin fails++; $display("FAIL rst_halted got %b want 0", halted); end
    tests++; if (pc !== 8'h00 || acc !== 8'h00) begin fails++; $display("FAIL rst_pc_acc got %h/%h want 00/00", pc, acc); end
    tests++; if ({unit, op, src} !== 12'hE00) begin fails++; $display("FAIL rst_alu got %b/%b/%h want 111/0/00", unit, op, src); end
    rst = 0;
    #1;
    tests++; if (req !== 1'b0) begin fails++; $display("FAIL idle_req got %b want 0", req); end
    @(negedge clk);
    tests++; if (req !== 1'b1 || addr !== 8'h00) begin fails++; $display("FAIL first_req got %b@%h want 1@00", req, addr); end
  endtask

  task automatic test_basic();
    load('{8'h6D, 8'h0B, 8'hE0});
    run_prog(0);
    tests++; if (acc !== 8'h08) begin fails++; $display("FAIL basic_acc got %h want 08", acc); end
    tests++; if (halted !== 1'b1) begin fails++; $display("FAIL basic_halted got %b want 1", halted); end
    tests++; if (pc !== 8'h02) begin fails++; $display("FAIL basic_pc got %h want 02", pc); end
    tests++; if (cycles != 6) begin fails++; $display("FAIL basic_cycles got %0d want 6", cycles); end
    tests++; if (alu_acc !== 8'h08) begin fails++; $display("FAIL basic_alu_acc got %h want 08", alu_acc); end
    tests++; if (req !== 1'b0) begin fails++; $display("FAIL halt_req got %b want 0", req); end
  endtask

  task automatic test_wait();
    load('{8'h6D, 8'h0B, 8'hE0});
    run_prog(3);
    tests++; if (acc !== 8'h08) begin fails++; $display("FAIL wait_acc got %h want 08", acc); end
    tests++; if (cycles != 15) begin fails++; $display("FAIL wait_cycles got %0d want 15", cycles); end
    tests++; if (addr_moved !== 1'b0) begin fails++; $display("FAIL wait_addr_stable got %b want 0", addr_moved); end
  endtask

  task automatic test_store();
    load('{8'h6B, 8'hA2, 8'h68, 8'h12, 8'hE0});
    run_prog(0);
    tests++; if (acc !== 8'hFD) begin fails++; $display("FAIL st_acc got %h want fd", acc); end
    tests++; if (ex_n != 5) begin fails++; $display("FAIL st_exec_count got %0d want 5", ex_n); end
    tests++; if (ex_uo[0] !== 4'b0110) begin fails++; $display("FAIL st_uo0 got %b want 0110", ex_uo[0]); end
    tests++; if (ex_uo[1] !== 4'b1110) begin fails++; $display("FAIL st_uo1 got %b want 1110", ex_uo[1]); end
    tests++; if (ex_uo[2] !== 4'b0110) begin fails++; $display("FAIL st_uo2 got %b want 0110", ex_uo[2]); end
    tests++; if (ex_uo[3] !== 4'b0001) begin fails++; $display("FAIL st_uo3 got %b want 0001", ex_uo[3]); end
  endtask

  task automatic test_loop();
    int bnez;
    load('{8'h6B, 8'h19, 8'hBF, 8'hE0});
    run_prog(0);
    bnez = 0;
    for (int i = 0; i < ex_n; i++) if (ex_pc[i] == 8'h02) bnez++;
    tests++; if (acc !== 8'h00) begin fails++; $display("FAIL loop_acc got %h want 00", acc); end
    tests++; if (pc !== 8'h03) begin fails++; $display("FAIL loop_pc got %h want 03", pc); end
    tests++; if (bnez != 3) begin fails++; $display("FAIL loop_bnez_execs got %0d want 3", bnez); end
    tests++; if (ex_n != 8) begin fails++; $display("FAIL loop_exec_count got %0d want 8", ex_n); end
  endtask

  task automatic test_wrap();
    load('{8'hCF});
    delay = 0;
    do_reset();
    repeat (3) @(negedge clk);
    tests++; if (pc !== 8'hFF || addr !== 8'hFF) begin fails++; $display("FAIL jmp_back got %h/%h want ff/ff", pc, addr); end
    repeat (2) @(negedge clk);
    tests++; if (pc !== 8'h00) begin fails++; $display("FAIL pc_wrap got %h want 00", pc); end
  endtask

  task automatic test_reset_mid();
    int i;
    load('{8'h6F, 8'h0F, 8'h0F, 8'h49});
    delay = 0;
    do_reset();
    for (i = 0; i < 40 && !(acc == 8'h2A && req); i++) @(negedge clk);
    tests++; if (acc !== 8'h2A || req !== 1'b1) begin fails++; $display("FAIL mid_setup got %h/%b want 2a/1", acc, req); end
    rst = 1;
    #1;
    tests++; if (req !== 1'b0 || acc !== 8'h00) begin fails++; $display("FAIL mid_reset got %b/%h want 0/00", req, acc); end
    ack_force = 1;
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    ack_force = 0;
    tests++; if (dut.ir_q !== 8'h00) begin fails++; $display("FAIL late_ack_ir got %h want 00", dut.ir_q); end
    tests++; if (req !== 1'b1 || pc !== 8'h00) begin fails++; $display("FAIL post_reset_fetch got %b/%h want 1/00", req, pc); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'hD0;
    test_reset();
    test_basic();
    test_wait();
    test_store();
    test_loop();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
